// File: rtl/fir_pkg.sv
// fir_pkg: shared state type, pipeline depth and saturation helper for the FIR engine
package fir_pkg;
   typedef enum logic [2:0] {CLEAR, IDLE, RUN, DRAIN, DONE} fir_state_t;
   localparam int PIPE_LAT = 2;
   function automatic longint sat_clamp(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction
endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: two-stage registered signed multiplier (operand reg, product reg) in SB_MAC16 style
module mac_mult_stage #(
   parameter int A_W = 24,
   parameter int B_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_en,
   input  logic signed [A_W-1:0]    i_a,
   input  logic signed [B_W-1:0]    i_b,
   output logic signed [A_W+B_W-1:0] o_p
);
   localparam int P_W = A_W + B_W;
   logic signed [A_W-1:0] r_a;
   logic signed [B_W-1:0] r_b;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
         o_p <= '0;
      end else if (i_en) begin
         r_a <= i_a;
         r_b <= i_b;
         o_p <= P_W'(r_a) * P_W'(r_b);
      end
   end
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR with one shared multiplier, shift scaling and saturation
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int NTAPS  = 8,
   parameter int DATA_W = 24,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 24,
   parameter int SHIFT  = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     coef_err,
   output logic signed [OUT_W-1:0]  y_out,
   output logic                     y_valid,
   output logic                     sat,
   output logic                     busy
);
   localparam int K_W   = $clog2(NTAPS);
   localparam int P_W   = DATA_W + COEF_W;
   localparam int ACC_W = P_W + K_W;
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_clamp(OUT_W));
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
   fir_state_t r_state, w_next;
   logic [K_W-1:0] r_wp, r_k;
   logic [PIPE_LAT-1:0] r_vld;
   logic signed [DATA_W-1:0] r_hist [NTAPS];
   logic signed [COEF_W-1:0] r_coef [NTAPS];
   logic signed [ACC_W-1:0] r_acc, w_t;
   logic signed [P_W-1:0] w_p;
   logic r_pend, w_accept, w_issue, w_hi, w_lo;
   assign w_accept     = r_state == IDLE && sample_valid;
   assign w_issue      = r_state == RUN;
   assign sample_ready = r_state == IDLE;
   assign busy         = r_state != IDLE;
   assign w_t          = r_acc >>> SHIFT;
   assign w_hi         = w_t > MAXV;
   assign w_lo         = w_t < MINV;
   // r_k doubles as the CLEAR index, the tap index and the DRAIN counter
   always_comb begin
      w_next = r_state;
      case (r_state)
         CLEAR:   w_next = (r_k == K_W'(NTAPS - 1)) ? IDLE : CLEAR;
         IDLE:    w_next = sample_valid ? RUN : IDLE;
         RUN:     w_next = (r_k == K_W'(NTAPS - 1)) ? DRAIN : RUN;
         DRAIN:   w_next = (r_k == K_W'(PIPE_LAT - 1)) ? DONE : DRAIN;
         DONE:    w_next = IDLE;
         default: w_next = CLEAR;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= CLEAR;
         r_k      <= '0;
         r_wp     <= '0;
         r_vld    <= '0;
         r_acc    <= '0;
         r_pend   <= 1'b0;
         y_out    <= '0;
         y_valid  <= 1'b0;
         sat      <= 1'b0;
         coef_err <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_k      <= (r_state == IDLE) ? '0 : r_k + 1'b1;
         r_wp     <= r_wp + K_W'(r_state == DONE);
         r_vld    <= {r_vld[PIPE_LAT-2:0], w_issue};
         r_acc    <= w_accept ? '0 : r_vld[PIPE_LAT-1] ? r_acc + ACC_W'(w_p) : r_acc;
         r_pend   <= r_state == DONE;
         y_valid  <= r_pend;
         coef_err <= coef_we && r_state != IDLE;
         if (r_pend) begin
            y_out <= w_hi ? MAXV[OUT_W-1:0] : w_lo ? MINV[OUT_W-1:0] : w_t[OUT_W-1:0];
            sat   <= w_hi | w_lo;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (r_state == CLEAR || w_accept)
         r_hist[(r_state == CLEAR) ? r_k : r_wp] <= (r_state == CLEAR) ? '0 : sample_in;
      if (coef_we && r_state == IDLE)
         r_coef[coef_addr] <= coef_data;
   end
   mac_mult_stage #(.A_W(DATA_W), .B_W(COEF_W)) u_mult (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_issue | (|r_vld)),
      .i_a   (r_hist[r_wp - r_k]),
      .i_b   (r_coef[r_k]),
      .o_p   (w_p)
   );
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed checks of impulse, handshake, saturation, reset and a reference-model run
module tb_fir_mac_engine;
   logic clk = 1'b0;
   logic reset, sample_valid, sample_ready, coef_we, coef_err, y_valid, sat, busy;
   logic signed [23:0] sample_in, y_out;
   logic [2:0] coef_addr;
   logic signed [15:0] coef_data;
   int total = 0, bad = 0, lat, rlo;
   logic signed [23:0] ry;
   logic rs;
   longint mh [8], mc [8];

   fir_mac_engine dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .coef_err(coef_err), .y_out(y_out), .y_valid(y_valid),
      .sat(sat), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag, input int exp);
      int n = 0;
      while (!sample_ready && n < 50) begin @(negedge clk); n++; end
      check(tag, n, exp);
   endtask

   task automatic wcoef(input int a, input int d);
      coef_we = 1'b1; coef_addr = 3'(a); coef_data = 16'(d);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   // mode: 0 plain, 1 stray sample_valid while busy, 2 coef write while busy, 3 coef h0=1 with accept
   task automatic push(input logic signed [23:0] x, input int mode);
      int n = 0;
      while (!sample_ready && n < 100) begin @(negedge clk); n++; end
      check("ready_wait", n < 100, 1);
      sample_in = x; sample_valid = 1'b1;
      if (mode == 3) begin coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd1; end
      @(negedge clk);
      sample_valid = 1'b0; coef_we = 1'b0;
      lat = -1; rlo = 0;
      for (int i = 0; i < 40; i++) begin
         if (i >= 1 && i <= 10 && !sample_ready) rlo++;
         if (mode == 1 && i == 3) begin sample_valid = 1'b1; sample_in = 24'sd777; end
         if (mode == 1 && i == 4) sample_valid = 1'b0;
         if (mode == 2 && i == 2) begin coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd99; end
         if (mode == 2 && i == 3) begin coef_we = 1'b0; check("cerr_pulse", coef_err, 1); end
         if (mode == 2 && i == 4) check("cerr_clear", coef_err, 0);
         if (y_valid) begin lat = i; ry = y_out; rs = sat; break; end
         @(negedge clk);
      end
      check("y_valid_seen", lat >= 0, 1);
   endtask

   task automatic impulse(input string p, input int mode);
      push(24'sd32768, mode);
      check({p, "_y1"}, ry, 1);
      check({p, "_sat1"}, rs, 0);
      for (int k = 1; k < 8; k++) begin
         push(24'sd0, 0);
         check($sformatf("%s_y%0d", p, k + 1), ry, k + 1);
         check($sformatf("%s_sat%0d", p, k + 1), rs, 0);
      end
   endtask

   initial begin
      longint acc, t, ey;
      logic signed [23:0] x;
      logic signed [15:0] c;
      logic es;
      int n, vs;
      reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      @(negedge clk); @(negedge clk);
      check("rst_y_out", y_out, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_sat", sat, 0);
      check("rst_coef_err", coef_err, 0);
      check("rst_ready", sample_ready, 0);
      check("rst_busy", busy, 1);
      reset = 1'b0;
      wait_ready("init_clear_len", 8);
      check("idle_busy", busy, 0);
      for (int k = 0; k < 8; k++) wcoef(k, k + 1);

      // handshake, latency and a stray valid while busy, then the rest of the impulse response
      push(24'sd32768, 1);
      check("latency", lat, 12);
      check("ready_low_cycles", rlo, 10);
      check("hs_y1", ry, 1);
      check("hs_sat1", rs, 0);
      @(negedge clk);
      check("y_valid_pulse", y_valid, 0);
      for (int k = 1; k < 16; k++) begin
         push(24'sd0, 0);
         check($sformatf("hs_y%0d", k + 1), ry, (k < 8) ? k + 1 : 0);
         check($sformatf("hs_sat%0d", k + 1), rs, 0);
      end

      impulse("cw_busy", 2);

      // reset in the middle of RUN
      sample_in = 24'sd32768; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n = 0; vs = 0;
      while (!sample_ready && n < 50) begin vs |= int'(y_valid); @(negedge clk); n++; end
      check("rst_clear_len", n, 8);
      check("rst_no_y_valid", vs, 0);
      impulse("post_rst", 0);

      // saturation
      for (int k = 0; k < 8; k++) wcoef(k, 32767);
      for (int k = 0; k < 8; k++) begin
         push(24'sd8388607, 0);
         if (k == 0) begin check("pos_first_y", ry, 8388351); check("pos_first_sat", rs, 0); end
      end
      check("pos_sat_y", ry, 8388607);
      check("pos_sat_flag", rs, 1);
      for (int k = 0; k < 8; k++) push(-24'sd8388608, 0);
      check("neg_sat_y", ry, -8388608);
      check("neg_sat_flag", rs, 1);
      for (int k = 1; k < 8; k++) wcoef(k, 0);
      push(24'sd100, 3);
      check("small_y", ry, 0);
      check("small_sat", rs, 0);

      // random samples against a bit-accurate model from a clean history
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_ready("rnd_clear_len", 8);
      for (int k = 0; k < 8; k++) begin
         c = 16'($urandom);
         mc[k] = longint'(c);
         mh[k] = 0;
         wcoef(k, int'(c));
      end
      for (int s = 0; s < 20; s++) begin
         x = 24'($urandom);
         for (int j = 7; j > 0; j--) mh[j] = mh[j-1];
         mh[0] = longint'(x);
         acc = 0;
         for (int k = 0; k < 8; k++) acc += mh[k] * mc[k];
         t = acc >>> 15;
         es = (t > 8388607 || t < -8388608);
         ey = (t > 8388607) ? 8388607 : (t < -8388608) ? -8388608 : t;
         push(x, 0);
         check($sformatf("rnd_y%0d", s), ry, ey);
         check($sformatf("rnd_sat%0d", s), rs, es);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
